// File: rtl/btb_train_gen_if.sv
// Fetch/execute/training bundle for btb_train_gen; the slave side is the generator.
// Statistics signals exist only when BTB_TRAIN_STAT_EN is defined.
interface btb_train_gen_if #(
    parameter int ADDR  = 32,
    parameter int DEPTH = 8
);
    localparam int OW = $clog2(DEPTH) + 1;

    logic            fetch_br_;
    logic            fetch_jump;
    logic [ADDR-1:0] fetch_pc;
    logic            pred_hit;
    logic [ADDR-1:0] pred_addr;
    logic            full;
    logic [OW-1:0]   occupancy;
    logic            exe_res_;
    logic            exe_taken;
    logic [ADDR-1:0] exe_tar_addr;
    logic            flush_;
    logic            underflow;
    logic            br_commit_;
    logic            br_taken_;
    logic            br_miss_;
    logic            jump_commit_;
    logic            jump_miss_;
    logic [ADDR-1:0] com_addr;
    logic [ADDR-1:0] com_tar_addr;
`ifdef BTB_TRAIN_STAT_EN
    logic [31:0]     stat_commit;
    logic [31:0]     stat_miss;

    modport master (
        output fetch_br_, fetch_jump, fetch_pc, pred_hit, pred_addr,
               exe_res_, exe_taken, exe_tar_addr, flush_,
        input  full, occupancy, underflow, br_commit_, br_taken_, br_miss_,
               jump_commit_, jump_miss_, com_addr, com_tar_addr,
               stat_commit, stat_miss
    );
    modport slave (
        input  fetch_br_, fetch_jump, fetch_pc, pred_hit, pred_addr,
               exe_res_, exe_taken, exe_tar_addr, flush_,
        output full, occupancy, underflow, br_commit_, br_taken_, br_miss_,
               jump_commit_, jump_miss_, com_addr, com_tar_addr,
               stat_commit, stat_miss
    );
`else
    modport master (
        output fetch_br_, fetch_jump, fetch_pc, pred_hit, pred_addr,
               exe_res_, exe_taken, exe_tar_addr, flush_,
        input  full, occupancy, underflow, br_commit_, br_taken_, br_miss_,
               jump_commit_, jump_miss_, com_addr, com_tar_addr
    );
    modport slave (
        input  fetch_br_, fetch_jump, fetch_pc, pred_hit, pred_addr,
               exe_res_, exe_taken, exe_tar_addr, flush_,
        output full, occupancy, underflow, br_commit_, br_taken_, br_miss_,
               jump_commit_, jump_miss_, com_addr, com_tar_addr
    );
`endif
endinterface

// File: rtl/btb_train_gen.sv
// BTB training generator: in-order queue of fetched branches/jumps, resolved at the head
// into registered commit/miss strobes. Optional statistics with BTB_TRAIN_STAT_EN.
module btb_train_gen #(
    parameter int ADDR  = 32,
    parameter int DEPTH = 8
) (
    input logic             clk,
    input logic             reset,
    btb_train_gen_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    function automatic logic calc_miss(input logic jump, input logic hit,
                                       input logic [ADDR-1:0] pred,
                                       input logic taken, input logic [ADDR-1:0] tar);
        if (jump)
            return !hit || (pred != tar);
        else
            return (hit != taken) || (taken && (pred != tar));
    endfunction

    logic            q_jump [DEPTH];
    logic            q_hit  [DEPTH];
    logic [ADDR-1:0] q_pc   [DEPTH];
    logic [ADDR-1:0] q_pred [DEPTH];

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [OW-1:0]   occ;
    logic            underflow_r;

    logic            br_commit_p1;
    logic            br_taken_p1;
    logic            br_miss_p1;
    logic            jump_commit_p1;
    logic            jump_miss_p1;
    logic [ADDR-1:0] com_addr_p1;
    logic [ADDR-1:0] com_tar_addr_p1;

    logic res;
    logic empty;
    logic is_full;
    logic deq;
    logic enq;
    logic miss;

    always_comb begin
        res     = !bus.exe_res_;
        empty   = (occ == '0);
        is_full = (occ == OW'(DEPTH));
        deq     = res && !empty;
        // A same-edge pop frees a slot for a stalled enqueue; flush drops enqueues.
        enq     = !bus.fetch_br_ && bus.flush_ && (!is_full || deq);
        miss    = calc_miss(q_jump[head], q_hit[head], q_pred[head],
                            bus.exe_taken, bus.exe_tar_addr);
    end

    // Queue storage holds data only; validity comes from occupancy.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_jump[tail] <= bus.fetch_jump;
            q_hit[tail]  <= bus.pred_hit;
            q_pc[tail]   <= bus.fetch_pc;
            q_pred[tail] <= bus.pred_addr;
        end
    end

    // Stage p1: registered training strobes and queue control.
    always_ff @(posedge clk) begin
        if (reset) begin
            head            <= '0;
            tail            <= '0;
            occ             <= '0;
            underflow_r     <= 1'b0;
            br_commit_p1    <= 1'b1;
            br_taken_p1     <= 1'b1;
            br_miss_p1      <= 1'b1;
            jump_commit_p1  <= 1'b1;
            jump_miss_p1    <= 1'b1;
            com_addr_p1     <= '0;
            com_tar_addr_p1 <= '0;
        end else begin
            br_commit_p1    <= 1'b1;
            br_taken_p1     <= 1'b1;
            br_miss_p1      <= 1'b1;
            jump_commit_p1  <= 1'b1;
            jump_miss_p1    <= 1'b1;
            com_addr_p1     <= '0;
            com_tar_addr_p1 <= '0;
            if (deq) begin
                if (q_jump[head]) begin
                    jump_commit_p1 <= 1'b0;
                    jump_miss_p1   <= !miss;
                end else begin
                    br_commit_p1 <= 1'b0;
                    br_taken_p1  <= !bus.exe_taken;
                    br_miss_p1   <= !miss;
                end
                com_addr_p1     <= q_pc[head];
                com_tar_addr_p1 <= bus.exe_tar_addr;
            end
            if (res && empty)
                underflow_r <= 1'b1;
            if (!bus.flush_) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (deq)
                    head <= head + PW'(1);
                if (enq)
                    tail <= tail + PW'(1);
                if (enq && !deq)
                    occ <= occ + OW'(1);
                else if (deq && !enq)
                    occ <= occ - OW'(1);
            end
        end
    end

    assign bus.full         = is_full;
    assign bus.occupancy    = occ;
    assign bus.underflow    = underflow_r;
    assign bus.br_commit_   = br_commit_p1;
    assign bus.br_taken_    = br_taken_p1;
    assign bus.br_miss_     = br_miss_p1;
    assign bus.jump_commit_ = jump_commit_p1;
    assign bus.jump_miss_   = jump_miss_p1;
    assign bus.com_addr     = com_addr_p1;
    assign bus.com_tar_addr = com_tar_addr_p1;

`ifdef BTB_TRAIN_STAT_EN
    logic [31:0] stat_commit_r;
    logic [31:0] stat_miss_r;

    // Counters survive flush and wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_commit_r <= '0;
            stat_miss_r   <= '0;
        end else if (deq) begin
            stat_commit_r <= stat_commit_r + 32'd1;
            if (miss)
                stat_miss_r <= stat_miss_r + 32'd1;
        end
    end

    assign bus.stat_commit = stat_commit_r;
    assign bus.stat_miss   = stat_miss_r;
`endif
endmodule

// File: tb/tb_btb_train_gen.sv
// Self-checking bench for btb_train_gen: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_btb_train_gen;
    localparam int ADDR  = 32;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    btb_train_gen_if #(.ADDR(ADDR), .DEPTH(DEPTH)) bus ();

    btb_train_gen #(.ADDR(ADDR), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            jump;
        logic [ADDR-1:0] pc;
        logic            hit;
        logic [ADDR-1:0] pred;
    } ent_t;

    ent_t        mq[$];
    logic        e_bc, e_bt, e_bm, e_jc, e_jm, e_uf;
    logic [31:0] e_ca, e_cta;
    logic [31:0] m_sc, m_sm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".br_commit_"}, 64'(bus.br_commit_), 64'(e_bc));
        chk({tag, ".br_taken_"}, 64'(bus.br_taken_), 64'(e_bt));
        chk({tag, ".br_miss_"}, 64'(bus.br_miss_), 64'(e_bm));
        chk({tag, ".jump_commit_"}, 64'(bus.jump_commit_), 64'(e_jc));
        chk({tag, ".jump_miss_"}, 64'(bus.jump_miss_), 64'(e_jm));
        chk({tag, ".com_addr"}, 64'(bus.com_addr), 64'(e_ca));
        chk({tag, ".com_tar_addr"}, 64'(bus.com_tar_addr), 64'(e_cta));
        chk({tag, ".occupancy"}, 64'(bus.occupancy), 64'(mq.size()));
        chk({tag, ".full"}, 64'(bus.full), 64'(mq.size() == DEPTH));
        chk({tag, ".underflow"}, 64'(bus.underflow), 64'(e_uf));
`ifdef BTB_TRAIN_STAT_EN
        chk({tag, ".stat_commit"}, 64'(bus.stat_commit), 64'(m_sc));
        chk({tag, ".stat_miss"}, 64'(bus.stat_miss), 64'(m_sm));
`endif
    endtask

    task automatic drive(input bit f, input bit j, input logic [31:0] pc, input bit hit,
                         input logic [31:0] pred, input bit r, input bit tk,
                         input logic [31:0] tar, input bit fl);
        bus.fetch_br_     = !f;
        bus.fetch_jump    = j;
        bus.fetch_pc      = pc;
        bus.pred_hit      = hit;
        bus.pred_addr     = pred;
        bus.exe_res_      = !r;
        bus.exe_taken     = tk;
        bus.exe_tar_addr  = tar;
        bus.flush_        = !fl;
    endtask

    // One clock of traffic: model predicts the outputs visible after the edge.
    task automatic cycle(input string tag, input bit f, input bit j, input logic [31:0] pc,
                         input bit hit, input logic [31:0] pred, input bit r, input bit tk,
                         input logic [31:0] tar, input bit fl);
        ent_t e;
        bit   miss;
        @(negedge clk);
        drive(f, j, pc, hit, pred, r, tk, tar, fl);
        {e_bc, e_bt, e_bm, e_jc, e_jm} = 5'b11111;
        e_ca  = '0;
        e_cta = '0;
        if (r) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.jump) miss = !e.hit || (e.pred != tar);
                else        miss = (e.hit != tk) || (tk && (e.pred != tar));
                if (e.jump) begin
                    e_jc = 1'b0;
                    e_jm = !miss;
                end else begin
                    e_bc = 1'b0;
                    e_bt = !tk;
                    e_bm = !miss;
                end
                e_ca  = e.pc;
                e_cta = tar;
                m_sc++;
                if (miss) m_sm++;
            end else begin
                e_uf = 1'b1;
            end
        end
        if (fl) mq.delete();
        else if (f && mq.size() < DEPTH) mq.push_back('{j, pc, hit, pred});
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic enq(input string tag, input bit j, input logic [31:0] pc, input bit hit,
                       input logic [31:0] pred);
        cycle(tag, 1, j, pc, hit, pred, 0, 0, 0, 0);
    endtask

    task automatic res(input string tag, input bit tk, input logic [31:0] tar);
        cycle(tag, 0, 0, 0, 0, 0, 1, tk, tar, 0);
    endtask

    // Reset while requests are active: reset must win.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 32'h55, 1, 32'h66, 1, 1, 32'h66, 0);
        mq.delete();
        {e_bc, e_bt, e_bm, e_jc, e_jm} = 5'b11111;
        e_ca = '0; e_cta = '0; e_uf = 1'b0; m_sc = '0; m_sm = '0;
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset("reset");

        // Jump mispredicted as not hit.
        enq("jm_enq", 1, 32'hdeadbe74, 0, 32'h0);
        res("jm_res", 0, 32'hcafecafc);
        chk("jm_commit", 64'(bus.jump_commit_), 64'd0);
        chk("jm_miss", 64'(bus.jump_miss_), 64'd0);
        chk("jm_addr", 64'(bus.com_addr), 64'hdeadbe74);
        chk("jm_tar", 64'(bus.com_tar_addr), 64'hcafecafc);
        idle("jm_release");
        chk("jm_release_commit", 64'(bus.jump_commit_), 64'd1);

        // Correct taken branch, wrong target, not-taken with hit.
        enq("cb_enq", 0, 32'h100, 1, 32'h200);
        res("cb_res", 1, 32'h200);
        chk("cb_taken", 64'(bus.br_taken_), 64'd0);
        chk("cb_miss", 64'(bus.br_miss_), 64'd1);
        enq("wt_enq", 0, 32'h100, 1, 32'h200);
        res("wt_res", 1, 32'h204);
        chk("wt_miss", 64'(bus.br_miss_), 64'd0);
        enq("nt_enq", 0, 32'h100, 1, 32'h200);
        res("nt_res", 0, 32'h104);
        chk("nt_miss", 64'(bus.br_miss_), 64'd0);
        chk("nt_taken", 64'(bus.br_taken_), 64'd1);

        // Fill across the pointer wrap, overflow drop, full enq+res, drain.
        for (int i = 0; i < DEPTH; i++)
            enq("fill", i[0], 32'h1000 + 32'(i) * 4, 1, 32'h40);
        enq("fill_drop", 0, 32'h2000, 0, 32'h0);
        chk("fill_full", 64'(bus.full), 64'd1);
        cycle("full_both", 1, 0, 32'h3000, 1, 32'h44, 1, 1, 32'h40, 0);
        chk("full_both_occ", 64'(bus.occupancy), 64'd8);
        for (int i = 0; i < DEPTH; i++)
            res("drain", 1, 32'h44);

        // Flush with a same-cycle resolve and enqueue, then underflow.
        for (int i = 0; i < 3; i++)
            enq("fl_enq", 0, 32'h500 + 32'(i), 0, 32'h0);
        cycle("fl_cyc", 1, 0, 32'h777, 0, 0, 1, 0, 32'h9, 1);
        chk("fl_head", 64'(bus.com_addr), 64'h500);
        chk("fl_occ", 64'(bus.occupancy), 64'd0);
        res("uf_res", 1, 32'h10);
        chk("uf_set", 64'(bus.underflow), 64'd1);
        idle("uf_sticky");

        // Enqueue and resolve while empty: accepted enqueue, no bypass.
        do_reset("reset2");
        cycle("empty_both", 1, 1, 32'h880, 1, 32'h990, 1, 1, 32'h990, 0);
        res("empty_both_pop", 1, 32'h990);

`ifdef BTB_TRAIN_STAT_EN
        do_reset("stat_reset");
        for (int i = 0; i < 5; i++)
            enq("st_enq", 0, 32'h600 + 32'(i), 1, 32'h70);
        for (int i = 0; i < 5; i++)
            res("st_res", 1, (i < 2) ? 32'h74 : 32'h70);
        chk("st_commit", 64'(bus.stat_commit), 64'd5);
        chk("st_miss", 64'(bus.stat_miss), 64'd2);
        enq("st_enq2", 1, 32'h610, 1, 32'h70);
        cycle("st_flush", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("st_commit_flush", 64'(bus.stat_commit), 64'd5);
        do_reset("st_reset2");
        chk("st_commit_rst", 64'(bus.stat_commit), 64'd0);
`endif

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] tars [4];
            tars = '{32'h40, 32'h44, 32'h80, 32'h84};
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_reset");
            end else begin
                cycle("rnd",
                      $urandom_range(0, 99) < 55,
                      $urandom_range(0, 3) == 0,
                      $urandom,
                      $urandom_range(0, 1),
                      tars[$urandom_range(0, 3)],
                      $urandom_range(0, 99) < 45,
                      $urandom_range(0, 1),
                      tars[$urandom_range(0, 3)],
                      $urandom_range(0, 39) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
